// File: rtl/type_rule_cfg_ctrl.sv
// Type-lookup rule table config sequencer: ADD/WRITE/DEL/CLEAR commands in; one-hot rule writes and a status/index response out.
// Latency: accept at edge N, wren in cycle N+1, response from N+2 (errors N+1, CLEAR N+RULE_NUM+1).
// Backpressure: o_cmd_ready is high only in IDLE; the response is held stable until i_resp_ready, and no new command is taken meanwhile.
//
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready             command handshake; i_cmd_op 0=ADD 1=WRITE 2=DEL 3=CLEAR
//   i_cmd_idx, i_cmd_typeData/typeMask/keyOffset/headShift/metaShift   command target and rule fields
//   o_rule_wren                         one-hot table write strobe
//   o_typeRule_*                        registered rule fields driven to the table
//   o_resp_valid/i_resp_ready           response handshake; o_resp_status 0=OK 1=FULL 2=BAD_IDX 3=UNSUPPORTED
//   o_resp_idx                          slot written/deleted (0 on error or CLEAR)
//   o_rule_occ, o_free_cnt              occupancy bitmap and registered free-slot count
// Build option: define TYPE_RULE_CLEAR_EN to compile in the CLEAR sweep; otherwise CLEAR answers UNSUPPORTED.

`ifndef RULE_NUM
`define RULE_NUM 6
`endif
`ifndef TYPE_NUM
`define TYPE_NUM 2
`endif
`ifndef TYPE_WIDTH
`define TYPE_WIDTH 8
`endif
`ifndef KEY_FILED_NUM
`define KEY_FILED_NUM 2
`endif
`ifndef KEY_OFFSET_WIDTH
`define KEY_OFFSET_WIDTH 6
`endif
`ifndef HEAD_SHIFT_WIDTH
`define HEAD_SHIFT_WIDTH 6
`endif
`ifndef META_SHIFT_WIDTH
`define META_SHIFT_WIDTH 6
`endif

module type_rule_cfg_ctrl #(
    parameter int RULE_NUM = `RULE_NUM,
    parameter int IDX_W    = $clog2(RULE_NUM)
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst_n,
    input  logic                                          i_cmd_valid,
    output logic                                          o_cmd_ready,
    input  logic [1:0]                                    i_cmd_op,
    input  logic [IDX_W-1:0]                              i_cmd_idx,
    input  logic [`TYPE_NUM*`TYPE_WIDTH-1:0]              i_cmd_typeData,
    input  logic [`TYPE_NUM*`TYPE_WIDTH-1:0]              i_cmd_typeMask,
    input  logic [`KEY_FILED_NUM*(`KEY_OFFSET_WIDTH+1)-1:0] i_cmd_keyOffset,
    input  logic [`HEAD_SHIFT_WIDTH-1:0]                  i_cmd_headShift,
    input  logic [`META_SHIFT_WIDTH-1:0]                  i_cmd_metaShift,
    output logic [RULE_NUM-1:0]                           o_rule_wren,
    output logic                                          o_typeRule_valid,
    output logic [`TYPE_NUM*`TYPE_WIDTH-1:0]              o_typeRule_typeData,
    output logic [`TYPE_NUM*`TYPE_WIDTH-1:0]              o_typeRule_typeMask,
    output logic [`KEY_FILED_NUM*(`KEY_OFFSET_WIDTH+1)-1:0] o_typeRule_keyOffset,
    output logic [`HEAD_SHIFT_WIDTH-1:0]                  o_typeRule_headShift,
    output logic [`META_SHIFT_WIDTH-1:0]                  o_typeRule_metaShift,
    output logic                                          o_resp_valid,
    input  logic                                          i_resp_ready,
    output logic [1:0]                                    o_resp_status,
    output logic [IDX_W-1:0]                              o_resp_idx,
    output logic [RULE_NUM-1:0]                           o_rule_occ,
    output logic [IDX_W:0]                                o_free_cnt
);

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_DEL   = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
`ifdef TYPE_RULE_CLEAR_EN
    localparam logic [1:0] ST_CLR   = 2'd2;
`endif
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_FULL    = 2'd1;
    localparam logic [1:0] RSP_BAD_IDX = 2'd2;
`ifndef TYPE_RULE_CLEAR_EN
    localparam logic [1:0] RSP_UNSUP   = 2'd3;
`endif

    localparam logic [IDX_W:0] RULE_NUM_L = (IDX_W+1)'(RULE_NUM);

    function automatic logic [RULE_NUM-1:0] onehot(input logic [IDX_W-1:0] i);
        return RULE_NUM'(1) << i;
    endfunction

    logic [1:0]           state;
    logic                 ready_q;
    logic [IDX_W-1:0]     tgt;
    logic                 wr_set;       // 1: WRITE cycle marks slot used, 0: frees it (DEL)
    logic [RULE_NUM-1:0]  occ;
    logic [IDX_W:0]       free_cnt;
    logic [RULE_NUM-1:0]  wren_q;
    logic                 rv_q;
    logic [1:0]           rsp_status_q;
    logic [IDX_W-1:0]     rsp_idx_q;
`ifdef TYPE_RULE_CLEAR_EN
    logic [IDX_W-1:0]     clr_cnt;
`endif

    logic                 accept;
    logic                 idx_ok;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic [IDX_W:0]       occ_pop;

    assign accept = i_cmd_valid & ready_q;
    assign idx_ok = {1'b0, i_cmd_idx} < RULE_NUM_L;

    // Descending scan so the last hit, i.e. the lowest free index, wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        occ_pop    = '0;
        for (int i = RULE_NUM - 1; i >= 0; i--) begin
            if (!occ[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < RULE_NUM; i++) begin
            occ_pop = occ_pop + (IDX_W+1)'(occ[i]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                <= ST_IDLE;
            ready_q              <= 1'b0;
            tgt                  <= '0;
            wr_set               <= 1'b0;
            occ                  <= '0;
            free_cnt             <= RULE_NUM_L;
            wren_q               <= '0;
            rv_q                 <= 1'b0;
            rsp_status_q         <= RSP_OK;
            rsp_idx_q            <= '0;
            o_typeRule_typeData  <= '0;
            o_typeRule_typeMask  <= '0;
            o_typeRule_keyOffset <= '0;
            o_typeRule_headShift <= '0;
            o_typeRule_metaShift <= '0;
`ifdef TYPE_RULE_CLEAR_EN
            clr_cnt              <= '0;
`endif
        end else begin
            // Count lags occupancy by one cycle.
            free_cnt <= RULE_NUM_L - occ_pop;
            case (state)
                ST_IDLE: begin
                    // Every accepted command leaves IDLE, so ready drops right after accept.
                    ready_q <= ~accept;
                    if (accept) begin
                        rsp_status_q <= RSP_OK;
                        rsp_idx_q    <= '0;
                        state        <= ST_RESP;
                        case (i_cmd_op)
                            OP_ADD, OP_WRITE: begin
                                if ((i_cmd_op == OP_ADD) ? free_found : idx_ok) begin
                                    tgt                  <= (i_cmd_op == OP_ADD) ? free_idx : i_cmd_idx;
                                    rsp_idx_q            <= (i_cmd_op == OP_ADD) ? free_idx : i_cmd_idx;
                                    wren_q               <= onehot((i_cmd_op == OP_ADD) ? free_idx : i_cmd_idx);
                                    wr_set               <= 1'b1;
                                    rv_q                 <= 1'b1;
                                    o_typeRule_typeData  <= i_cmd_typeData;
                                    o_typeRule_typeMask  <= i_cmd_typeMask;
                                    o_typeRule_keyOffset <= i_cmd_keyOffset;
                                    o_typeRule_headShift <= i_cmd_headShift;
                                    o_typeRule_metaShift <= i_cmd_metaShift;
                                    state                <= ST_WRITE;
                                end else begin
                                    rsp_status_q <= (i_cmd_op == OP_ADD) ? RSP_FULL : RSP_BAD_IDX;
                                end
                            end
                            OP_DEL: begin
                                if (idx_ok) begin
                                    tgt                  <= i_cmd_idx;
                                    rsp_idx_q            <= i_cmd_idx;
                                    wren_q               <= onehot(i_cmd_idx);
                                    wr_set               <= 1'b0;
                                    rv_q                 <= 1'b0;
                                    o_typeRule_typeData  <= '0;
                                    o_typeRule_typeMask  <= '0;
                                    o_typeRule_keyOffset <= '0;
                                    o_typeRule_headShift <= '0;
                                    o_typeRule_metaShift <= '0;
                                    state                <= ST_WRITE;
                                end else begin
                                    rsp_status_q <= RSP_BAD_IDX;
                                end
                            end
                            default: begin
`ifdef TYPE_RULE_CLEAR_EN
                                clr_cnt <= '0;
                                wren_q  <= onehot('0);
                                rv_q    <= 1'b0;
                                state   <= ST_CLR;
`else
                                rsp_status_q <= RSP_UNSUP;
`endif
                            end
                        endcase
                    end
                end
                ST_WRITE: begin
                    occ[tgt] <= wr_set;
                    wren_q   <= '0;
                    rv_q     <= 1'b0;
                    state    <= ST_RESP;
                end
`ifdef TYPE_RULE_CLEAR_EN
                ST_CLR: begin
                    occ[clr_cnt] <= 1'b0;
                    if (clr_cnt == IDX_W'(RULE_NUM - 1)) begin
                        wren_q <= '0;
                        state  <= ST_RESP;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                        wren_q  <= onehot(clr_cnt + 1'b1);
                    end
                end
`endif
                ST_RESP: begin
                    if (i_resp_ready) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    wren_q <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready      = ready_q;
    assign o_rule_wren      = wren_q;
    assign o_typeRule_valid = rv_q;
    assign o_resp_valid     = (state == ST_RESP);
    assign o_resp_status    = rsp_status_q;
    assign o_resp_idx       = rsp_idx_q;
    assign o_rule_occ       = occ;
    assign o_free_cnt       = free_cnt;

endmodule

// File: tb/tb_type_rule_cfg_ctrl.sv
`timescale 1ns/1ps

`ifndef RULE_NUM
`define RULE_NUM 6
`endif
`ifndef TYPE_NUM
`define TYPE_NUM 2
`endif
`ifndef TYPE_WIDTH
`define TYPE_WIDTH 8
`endif
`ifndef KEY_FILED_NUM
`define KEY_FILED_NUM 2
`endif
`ifndef KEY_OFFSET_WIDTH
`define KEY_OFFSET_WIDTH 6
`endif
`ifndef HEAD_SHIFT_WIDTH
`define HEAD_SHIFT_WIDTH 6
`endif
`ifndef META_SHIFT_WIDTH
`define META_SHIFT_WIDTH 6
`endif

module tb_type_rule_cfg_ctrl;

    localparam int RN    = 6;
    localparam int IDX_W = 3;
    localparam int TD_W  = `TYPE_NUM*`TYPE_WIDTH;
    localparam int KO_W  = `KEY_FILED_NUM*(`KEY_OFFSET_WIDTH+1);
    localparam int HS_W  = `HEAD_SHIFT_WIDTH;
    localparam int MS_W  = `META_SHIFT_WIDTH;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [IDX_W-1:0]  cmd_idx = '0;
    logic [TD_W-1:0]   cmd_td = '0, cmd_tm = '0;
    logic [KO_W-1:0]   cmd_ko = '0;
    logic [HS_W-1:0]   cmd_hs = '0;
    logic [MS_W-1:0]   cmd_ms = '0;
    logic [RN-1:0]     wren;
    logic              rv;
    logic [TD_W-1:0]   r_td, r_tm;
    logic [KO_W-1:0]   r_ko;
    logic [HS_W-1:0]   r_hs;
    logic [MS_W-1:0]   r_ms;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [1:0]        resp_status;
    logic [IDX_W-1:0]  resp_idx;
    logic [RN-1:0]     occ;
    logic [IDX_W:0]    free_cnt;

    int checks = 0;
    int errors = 0;

    // Observations from the most recent command.
    logic [RN-1:0]     obs_hist [0:47];
    int                obs_wcnt, obs_first, obs_resp_k;
    logic              obs_valid_any, obs_last_valid, obs_multi;
    logic [TD_W-1:0]   obs_td;
    logic [1:0]        obs_status;
    logic [IDX_W-1:0]  obs_idx;
    time               obs_acc_t;

    type_rule_cfg_ctrl #(.RULE_NUM(RN), .IDX_W(IDX_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_idx(cmd_idx),
        .i_cmd_typeData(cmd_td), .i_cmd_typeMask(cmd_tm),
        .i_cmd_keyOffset(cmd_ko), .i_cmd_headShift(cmd_hs), .i_cmd_metaShift(cmd_ms),
        .o_rule_wren(wren), .o_typeRule_valid(rv),
        .o_typeRule_typeData(r_td), .o_typeRule_typeMask(r_tm),
        .o_typeRule_keyOffset(r_ko), .o_typeRule_headShift(r_hs), .o_typeRule_metaShift(r_ms),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_resp_status(resp_status), .o_resp_idx(resp_idx),
        .o_rule_occ(occ), .o_free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    // Issues one command and watches it until the response appears (returns on that negedge).
    task automatic do_cmd(input logic [1:0] op, input logic [IDX_W-1:0] idx, input logic [TD_W-1:0] td);
        int n;
        bit got;
        n = 0;
        got = 0;
        obs_wcnt = 0; obs_first = 0; obs_resp_k = 0;
        obs_valid_any = 0; obs_last_valid = 0; obs_multi = 0;
        obs_td = '0; obs_status = 2'bxx; obs_idx = 'x;
        for (int k = 0; k < 48; k++) obs_hist[k] = '0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            $display("FAIL cmd_ready_timeout: ready=%0b want 1", cmd_ready);
            errors++; checks++;
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx;
        cmd_td = td; cmd_tm = ~td; cmd_ko = KO_W'(14'h1A2B); cmd_hs = 6'h15; cmd_ms = 6'h2A;
        @(posedge clk);
        obs_acc_t = $time;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            obs_hist[k] = wren;
            if (wren != '0) begin
                obs_wcnt++;
                if (obs_first == 0) obs_first = k;
                obs_valid_any  = obs_valid_any | rv;
                obs_last_valid = rv;
                obs_td         = r_td;
                if ($countones(wren) > 1) obs_multi = 1;
            end
            if (resp_valid) begin
                obs_resp_k = k; obs_status = resp_status; obs_idx = resp_idx;
                got = 1;
                break;
            end
        end
        if (!got) begin
            $display("FAIL resp_timeout: resp_valid=%0b want 1", resp_valid);
            errors++; checks++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || wren !== '0 || occ !== '0 || resp_valid !== 1'b0 || rv !== 1'b0) begin
            $display("FAIL reset_outputs: ready=%0b wren=%h occ=%h resp_valid=%0b valid=%0b want all 0",
                     cmd_ready, wren, occ, resp_valid, rv);
            errors++;
        end
        checks++;
        if (free_cnt !== 4'd6) begin
            $display("FAIL reset_free_cnt: got %0d want 6", free_cnt); errors++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL ready_after_reset: got %0b want 1", cmd_ready); errors++;
        end
    endtask

    task automatic test_add();
        logic [TD_W-1:0] td;
        logic [RN-1:0]   ew;
        for (int i = 0; i < 3; i++) begin
            td = TD_W'(16'hA000 + i);
            ew = RN'(1) << i;
            do_cmd(2'd0, '0, td);
            checks++;
            if (obs_status !== 2'd0 || obs_idx !== IDX_W'(i)) begin
                $display("FAIL add_resp: status=%0d idx=%0d want 0/%0d", obs_status, obs_idx, i); errors++;
            end
            checks++;
            if (obs_hist[1] !== ew || obs_wcnt != 1 || obs_first != 1 || obs_resp_k != 2) begin
                $display("FAIL add_timing: wren=%h wcycles=%0d first=%0d resp_at=%0d want %h/1/1/2",
                         obs_hist[1], obs_wcnt, obs_first, obs_resp_k, ew); errors++;
            end
            checks++;
            if (obs_last_valid !== 1'b1 || obs_td !== td) begin
                $display("FAIL add_fields: valid=%0b td=%h want 1/%h", obs_last_valid, obs_td, td); errors++;
            end
        end
        @(negedge clk);
        checks++;
        if (occ !== 6'h07 || free_cnt !== 4'd3) begin
            $display("FAIL add_occ: occ=%h free=%0d want 07/3", occ, free_cnt); errors++;
        end
    endtask

    task automatic test_del_add();
        do_cmd(2'd2, 3'd1, 16'hFFFF);
        checks++;
        if (obs_status !== 2'd0 || obs_idx !== 3'd1 || obs_hist[1] !== 6'h02 || obs_last_valid !== 1'b0 || obs_td !== '0) begin
            $display("FAIL del_resp: status=%0d idx=%0d wren=%h valid=%0b td=%h want 0/1/02/0/0000",
                     obs_status, obs_idx, obs_hist[1], obs_last_valid, obs_td); errors++;
        end
        @(negedge clk);
        checks++;
        if (occ !== 6'h05 || free_cnt !== 4'd4) begin
            $display("FAIL del_occ: occ=%h free=%0d want 05/4", occ, free_cnt); errors++;
        end
        do_cmd(2'd0, 3'd7, 16'hB001);
        @(negedge clk);
        checks++;
        if (obs_idx !== 3'd1 || obs_hist[1] !== 6'h02 || occ !== 6'h07) begin
            $display("FAIL add_lowest_free: idx=%0d wren=%h occ=%h want 1/02/07", obs_idx, obs_hist[1], occ); errors++;
        end
    endtask

    task automatic test_full();
        for (int i = 3; i < 6; i++) do_cmd(2'd0, '0, TD_W'(16'hC000 + i));
        @(negedge clk);
        checks++;
        if (occ !== 6'h3F || free_cnt !== 4'd0) begin
            $display("FAIL fill_occ: occ=%h free=%0d want 3F/0", occ, free_cnt); errors++;
        end
        do_cmd(2'd0, '0, 16'hDEAD);
        checks++;
        if (obs_status !== 2'd1 || obs_idx !== 3'd0 || obs_wcnt != 0 || obs_resp_k != 1) begin
            $display("FAIL add_full: status=%0d idx=%0d wcycles=%0d resp_at=%0d want 1/0/0/1",
                     obs_status, obs_idx, obs_wcnt, obs_resp_k); errors++;
        end
        checks++;
        if (occ !== 6'h3F) begin
            $display("FAIL full_occ: occ=%h want 3F", occ); errors++;
        end
    endtask

    task automatic test_overwrite();
        do_cmd(2'd1, 3'd2, 16'h5A5A);
        @(negedge clk);
        checks++;
        if (obs_status !== 2'd0 || obs_idx !== 3'd2 || obs_hist[1] !== 6'h04 || obs_last_valid !== 1'b1
            || obs_td !== 16'h5A5A || occ !== 6'h3F) begin
            $display("FAIL overwrite: status=%0d idx=%0d wren=%h valid=%0b td=%h occ=%h want 0/2/04/1/5a5a/3F",
                     obs_status, obs_idx, obs_hist[1], obs_last_valid, obs_td, occ); errors++;
        end
    endtask

    task automatic test_bad_idx();
        do_cmd(2'd1, 3'd6, 16'h1111);
        checks++;
        if (obs_status !== 2'd2 || obs_idx !== 3'd0 || obs_wcnt != 0 || obs_resp_k != 1) begin
            $display("FAIL write_bad_idx: status=%0d idx=%0d wcycles=%0d resp_at=%0d want 2/0/0/1",
                     obs_status, obs_idx, obs_wcnt, obs_resp_k); errors++;
        end
        do_cmd(2'd2, 3'd7, 16'h2222);
        checks++;
        if (obs_status !== 2'd2 || obs_wcnt != 0 || occ !== 6'h3F) begin
            $display("FAIL del_bad_idx: status=%0d wcycles=%0d occ=%h want 2/0/3F", obs_status, obs_wcnt, occ); errors++;
        end
    endtask

    task automatic test_del_empty();
        do_cmd(2'd2, 3'd5, '0);
        do_cmd(2'd2, 3'd5, '0);
        @(negedge clk);
        checks++;
        if (obs_status !== 2'd0 || obs_idx !== 3'd5 || obs_hist[1] !== 6'h20 || obs_last_valid !== 1'b0) begin
            $display("FAIL del_empty: status=%0d idx=%0d wren=%h valid=%0b want 0/5/20/0",
                     obs_status, obs_idx, obs_hist[1], obs_last_valid); errors++;
        end
        checks++;
        if (occ !== 6'h1F || free_cnt !== 4'd1) begin
            $display("FAIL del_empty_occ: occ=%h free=%0d want 1F/1", occ, free_cnt); errors++;
        end
    endtask

    task automatic test_resp_hold();
        int bad;
        bad = 0;
        resp_ready = 1'b0;
        do_cmd(2'd0, '0, 16'h7777);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_status !== 2'd0 || resp_idx !== 3'd5 || cmd_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL resp_hold: unstable cycles=%0d want 0 (last valid=%0b status=%0d idx=%0d ready=%0b)",
                     bad, resp_valid, resp_status, resp_idx, cmd_ready); errors++;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || cmd_ready !== 1'b1 || occ !== 6'h3F) begin
            $display("FAIL resp_release: resp_valid=%0b ready=%0b occ=%h want 0/1/3F", resp_valid, cmd_ready, occ); errors++;
        end
    endtask

    task automatic test_clear();
        do_cmd(2'd3, '0, '0);
        @(negedge clk);
`ifdef TYPE_RULE_CLEAR_EN
        checks++;
        if (obs_status !== 2'd0 || obs_idx !== 3'd0 || obs_wcnt != RN || obs_first != 1 || obs_resp_k != RN + 1
            || obs_valid_any !== 1'b0 || obs_multi !== 1'b0) begin
            $display("FAIL clear_resp: status=%0d idx=%0d wcycles=%0d first=%0d resp_at=%0d valid=%0b multi=%0b want 0/0/6/1/7/0/0",
                     obs_status, obs_idx, obs_wcnt, obs_first, obs_resp_k, obs_valid_any, obs_multi); errors++;
        end
        for (int k = 1; k <= RN; k++) begin
            checks++;
            if (obs_hist[k] !== RN'(1) << (k - 1)) begin
                $display("FAIL clear_wren_seq: cycle %0d wren=%h want %h", k, obs_hist[k], RN'(1) << (k - 1)); errors++;
            end
        end
        checks++;
        if (occ !== 6'h00 || free_cnt !== 4'd6) begin
            $display("FAIL clear_occ: occ=%h free=%0d want 00/6", occ, free_cnt); errors++;
        end
`else
        checks++;
        if (obs_status !== 2'd3 || obs_idx !== 3'd0 || obs_wcnt != 0 || obs_resp_k != 1) begin
            $display("FAIL clear_unsupported: status=%0d idx=%0d wcycles=%0d resp_at=%0d want 3/0/0/1",
                     obs_status, obs_idx, obs_wcnt, obs_resp_k); errors++;
        end
        checks++;
        if (occ !== 6'h3F || free_cnt !== 4'd0) begin
            $display("FAIL clear_unsupported_occ: occ=%h free=%0d want 3F/0", occ, free_cnt); errors++;
        end
`endif
    endtask

    task automatic test_reset_mid();
`ifdef TYPE_RULE_CLEAR_EN
        do_cmd(2'd0, '0, 16'h0101);
        do_cmd(2'd0, '0, 16'h0202);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wren !== 6'h02 || occ !== 6'h02) begin
            $display("FAIL mid_clear: wren=%h occ=%h want 02/02", wren, occ); errors++;
        end
`else
        resp_ready = 1'b0;
        do_cmd(2'd2, 3'd0, '0);
        @(negedge clk);
        checks++;
        if (occ !== 6'h3E || resp_valid !== 1'b1) begin
            $display("FAIL mid_resp: occ=%h resp_valid=%0b want 3E/1", occ, resp_valid); errors++;
        end
`endif
        rst_n = 1'b0;
        #1;
        checks++;
        if (wren !== '0 || occ !== '0 || cmd_ready !== 1'b0 || resp_valid !== 1'b0 || free_cnt !== 4'd6) begin
            $display("FAIL reset_mid: wren=%h occ=%h ready=%0b resp_valid=%0b free=%0d want 0/0/0/0/6",
                     wren, occ, cmd_ready, resp_valid, free_cnt); errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        time t0;
        do_cmd(2'd0, '0, 16'h3131);
        t0 = obs_acc_t;
        checks++;
        if (obs_idx !== 3'd0 || obs_status !== 2'd0) begin
            $display("FAIL b2b_first: idx=%0d status=%0d want 0/0", obs_idx, obs_status); errors++;
        end
        do_cmd(2'd0, '0, 16'h3232);
        checks++;
        if (obs_idx !== 3'd1 || obs_acc_t - t0 != 30) begin
            $display("FAIL b2b_spacing: idx=%0d spacing=%0t want 1/30", obs_idx, obs_acc_t - t0); errors++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_del_add();
        test_full();
        test_overwrite();
        test_bad_idx();
        test_del_empty();
        test_resp_hold();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/type_rule_cfg_ctrl.md
# type_rule_cfg_ctrl

Configuration sequencer for the type-lookup rule table in each parser stage. Accepts add/write/delete/clear commands over a valid/ready port and drives the table's one-hot rule write enables and rule fields. Tracks slot occupancy and auto-allocates the lowest free slot, then returns a status/index response. Sits between the host config bus decoder and the per-stage lookup tables.

## Interface
- RULE_NUM, default `` `RULE_NUM ``: number of rule slots.
- IDX_W, default $clog2(RULE_NUM): slot index width.
---
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid.
- i_cmd_op  in  2  0=ADD, 1=WRITE, 2=DEL, 3=CLEAR.
- i_cmd_idx  in  IDX_W  target slot for WRITE/DEL.
- i_cmd_typeData, i_cmd_typeMask  in  `` `TYPE_NUM*`TYPE_WIDTH ``  match data/mask.
- i_cmd_keyOffset  in  `` `KEY_FILED_NUM*(`KEY_OFFSET_WIDTH+1) ``  key offsets.
- i_cmd_headShift  in  `` `HEAD_SHIFT_WIDTH ``; i_cmd_metaShift  in  `` `META_SHIFT_WIDTH ``.
- o_rule_wren  out  RULE_NUM  one-hot write strobe to table.
- o_typeRule_valid  out  1; o_typeRule_typeData/typeMask/keyOffset/headShift/metaShift  out  same widths as inputs: registered rule fields.
- o_resp_valid  out  1; i_resp_ready  in  1: response handshake.
- o_resp_status  out  2  0=OK, 1=FULL, 2=BAD_IDX, 3=UNSUPPORTED.
- o_resp_idx  out  IDX_W  slot written/deleted (0 on error/CLEAR).
- o_rule_occ  out  RULE_NUM  occupancy bitmap.
- o_free_cnt  out  IDX_W+1  free slot count.

## Operation
- FSM: IDLE, WRITE, CLR, RESP. Reset: IDLE; all outputs 0, o_cmd_ready 0 during reset, o_free_cnt = RULE_NUM, o_rule_occ = 0.
- IDLE: o_cmd_ready=1. On accept, latch command; compute target:
  - ADD: lowest index with occ=0; none → status FULL, go RESP, no write.
  - WRITE/DEL: i_cmd_idx ≥ RULE_NUM → BAD_IDX, go RESP, no write.
  - Valid target → WRITE. CLEAR → CLR with counter=0.
- WRITE (1 cycle): o_rule_wren = one-hot(target); o_typeRule_valid = 1 for ADD/WRITE, 0 for DEL; fields = latched command (zeros for DEL). occ[target] set/cleared same edge. Status OK → RESP.
- DEL of empty slot: still writes, status OK (idempotent). WRITE to occupied slot overwrites, occ unchanged.
- CLR: one slot per cycle, counter 0..RULE_NUM-1, wren=one-hot(counter), valid=0; occ[counter] cleared. After last slot → RESP, status OK.
- RESP: o_resp_valid held with stable status/idx until i_resp_ready; then IDLE.
- o_free_cnt = RULE_NUM − popcount(occ), registered, updated the cycle after occ changes.
- o_rule_wren is 0 in all states except WRITE/CLR; never more than one bit set.

## Timing
- Accept at edge N → wren asserted in cycle N+1 → o_resp_valid from N+2.
- CLEAR: wren cycles N+1..N+RULE_NUM, o_resp_valid from N+RULE_NUM+1.
- Error commands: o_resp_valid from N+1, no wren.
- Minimum command spacing 3 cycles (accept, write, resp with ready=1).
- i_resp_ready high while resp_valid: RESP→IDLE next edge; o_cmd_ready high that next cycle.
- Reset mid-CLR/WRITE: immediate return to IDLE, wren=0, occ cleared; table contents not guaranteed; software must re-CLEAR.

## Configuration
- `` `TYPE_RULE_CLEAR_EN `` defined: CLEAR op and CLR state compiled in as above.
- Undefined: CLR state absent; CLEAR returns UNSUPPORTED at N+1, no wren, occ unchanged.

## Test plan
- Reset → o_free_cnt=RULE_NUM, occ=0, wren=0; ADD ×3 → idx 0,1,2, status OK, wren 0x1,0x2,0x4, free_cnt=RULE_NUM−3.
- DEL idx 1 then ADD → ADD returns idx 1 (lowest free), occ=0x7.
- Fill all RULE_NUM slots, ADD → status FULL, no wren, occ all ones.
- WRITE idx=RULE_NUM (if not power of two) → BAD_IDX; DEL empty slot 5 → OK, wren bit 5, valid=0.
- CLEAR with slots full → RULE_NUM consecutive one-hot wren, valid=0, occ=0, free_cnt=RULE_NUM; without macro → UNSUPPORTED.
- Hold i_resp_ready=0 for 10 cycles → resp stable, o_cmd_ready=0; assert reset mid-CLEAR → IDLE, wren=0, occ=0.
